// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end of a multi-cycle RISC-V style core.
// Holds the PC and the instruction register (IR). It requests the word at PC
// from instruction memory, waits up to MAX_WAIT cycles for an acknowledge,
// presents the fetched word to the control unit, and loads the next PC when
// the datapath retires the current instruction. A fetch timeout or a
// misaligned next PC parks the unit in a sticky fault until reset.
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         asynchronous active-high reset
//   PCWrite     retire the instruction in IR and load NextPC
//   NextPC      next PC from the datapath (PC+4, branch or jump target)
//   ImemReq     instruction memory request
//   ImemAddr    instruction memory address (always the current PC)
//   ImemAck     memory returns ImemData this cycle
//   ImemData    instruction word, valid with ImemAck
//   Instr       instruction register contents
//   opcode      Instr[6:0]
//   funct3      Instr[14:12]
//   PC          address of the instruction held in Instr
//   PC_plus4    PC + 4, wrapping modulo 2^32
//   InstrValid  Instr holds a fetched instruction
//   Fault       sticky fault (fetch timeout or misaligned NextPC)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWrite,
  input  logic [31:0] NextPC,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] Instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        InstrValid,
  output logic        Fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    FAULT
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [7:0]  wait_cnt;

  logic        load_instr;
  logic        load_pc;
  logic        cnt_clr;
  logic        cnt_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= NOP_INSTR;
      wait_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (load_instr) ir <= ImemData;
      if (load_pc)    pc <= NextPC;
      if (cnt_clr)
        wait_cnt <= 8'd0;
      else if (cnt_inc)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: next_state = REQ;
      REQ: begin
        if (ImemAck) begin
          load_instr = 1'b1;
          next_state = VALID;
        end else begin
          cnt_clr    = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (ImemAck) begin
          load_instr = 1'b1;
          next_state = VALID;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = FAULT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      VALID: begin
        // A misaligned target is never loaded; the offending PC stays visible.
        if (PCWrite) begin
          if (NextPC[1:0] == 2'b00) begin
            load_pc    = 1'b1;
            next_state = REQ;
          end else begin
            next_state = FAULT;
          end
        end
      end
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  // Outputs depend on state only, so reset drops the request immediately.
  assign ImemReq    = (state == REQ) || (state == WAIT);
  assign InstrValid = (state == VALID);
  assign Fault      = (state == FAULT);
  assign ImemAddr   = pc;
  assign PC         = pc;
  assign PC_plus4   = pc + 32'd4;
  assign Instr      = ir;
  assign opcode     = ir[6:0];
  assign funct3     = ir[14:12];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// behavioural model of the fetch rules kept in the bench.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MW     = 15;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PCWrite = 1'b0;
  logic [31:0] NextPC = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic [31:0] Instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        InstrValid;
  logic        Fault;

  fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST), .PCWrite(PCWrite), .NextPC(NextPC),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
    .ImemData(ImemData), .Instr(Instr), .opcode(opcode), .funct3(funct3),
    .PC(PC), .PC_plus4(PC_plus4), .InstrValid(InstrValid), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Behavioural model: what the unit is doing, not how it encodes it.
  bit          m_starting;   // one cycle after reset before the first request
  bit          m_fetching;   // request outstanding
  bit          m_first;      // first cycle of the current request
  int          m_waits;      // wait cycles that ended without an acknowledge
  bit          m_valid;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starting = 1; m_fetching = 0; m_first = 0; m_waits = 0;
    m_valid = 0; m_fault = 0; m_pc = RST_PC; m_instr = NOP;
  endtask

  task automatic model_edge(input logic pcw, input logic [31:0] npc,
                            input logic ack, input logic [31:0] data);
    if (m_starting) begin
      m_starting = 0; m_fetching = 1; m_first = 1;
    end else if (m_fetching) begin
      if (ack) begin
        m_instr = data; m_fetching = 0; m_valid = 1;
      end else if (m_first) begin
        m_first = 0; m_waits = 0;
      end else begin
        m_waits++;
        if (m_waits == MW) begin
          m_fetching = 0; m_fault = 1;
        end
      end
    end else if (m_valid && pcw) begin
      m_valid = 0;
      if (npc[1:0] == 2'b00) begin
        m_pc = npc; m_fetching = 1; m_first = 1;
      end else begin
        m_fault = 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_ImemReq"},    ImemReq,    m_fetching);
    chk({ph, "_ImemAddr"},   ImemAddr,   m_pc);
    chk({ph, "_PC"},         PC,         m_pc);
    chk({ph, "_PC_plus4"},   PC_plus4,   m_pc + 32'd4);
    chk({ph, "_Instr"},      Instr,      m_instr);
    chk({ph, "_opcode"},     opcode,     m_instr[6:0]);
    chk({ph, "_funct3"},     funct3,     m_instr[14:12]);
    chk({ph, "_InstrValid"}, InstrValid, m_valid);
    chk({ph, "_Fault"},      Fault,      m_fault);
  endtask

  task automatic step(input string ph, input logic pcw, input logic [31:0] npc,
                      input logic ack, input logic [31:0] data);
    PCWrite = pcw; NextPC = npc; ImemAck = ack; ImemData = data;
    @(posedge CLK);
    #1;
    model_edge(pcw, npc, ack, data);
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    PCWrite = 0; ImemAck = 0;
    RST = 1;
    #1;
    model_reset();
    check_all({ph, "_in"});
    @(posedge CLK);
    #1;
    RST = 0;
    check_all({ph, "_rel"});
  endtask

  int req_cycles;

  initial begin
    model_reset();
    // Reset state
    @(posedge CLK);
    #1;
    check_all("rst");
    RST = 0;
    // First request one edge after release
    step("boot", 0, 32'h0, 0, 32'h0);
    chk("boot_req_rises", ImemReq, 1'b1);

    // Zero-wait fetch
    step("zw", 0, 32'h0, 1, 32'h0050_0093);
    chk("zw_instr", Instr, 32'h0050_0093);
    chk("zw_opcode", opcode, 7'b0010011);
    chk("zw_funct3", funct3, 3'b000);
    chk("zw_pc", PC, 32'h0);
    chk("zw_valid", InstrValid, 1'b1);

    // Retire to 0x104
    step("ret", 1, 32'h0000_0104, 0, 32'h0);
    chk("ret_pc", PC, 32'h0000_0104);
    chk("ret_pc4", PC_plus4, 32'h0000_0108);
    chk("ret_addr", ImemAddr, 32'h0000_0104);
    chk("ret_valid_drop", InstrValid, 1'b0);
    req_cycles = ImemReq ? 1 : 0;

    // Three wait cycles, spurious PCWrite in WAIT, ack in the third
    step("w1", 0, 32'h0, 0, 32'h0);
    req_cycles += ImemReq ? 1 : 0;
    step("w2", 1, 32'h0000_0200, 0, 32'h0);
    req_cycles += ImemReq ? 1 : 0;
    chk("spur_pcw_pc", PC, 32'h0000_0104);
    step("w3", 0, 32'h0, 0, 32'h0);
    req_cycles += ImemReq ? 1 : 0;
    step("wack", 0, 32'h0, 1, 32'h0041_8193);
    chk("wait_req_cycles", req_cycles, 4);
    chk("wait_instr", Instr, 32'h0041_8193);
    chk("wait_fault", Fault, 1'b0);

    // Spurious ack in VALID
    step("spur_ack", 0, 32'h0, 1, 32'hDEAD_BEEF);
    chk("spur_ack_instr", Instr, 32'h0041_8193);

    // Misaligned NextPC
    step("mis", 1, 32'h0000_0106, 0, 32'h0);
    chk("mis_fault", Fault, 1'b1);
    chk("mis_pc", PC, 32'h0000_0104);
    step("fault_ack", 0, 32'h0, 1, 32'h1234_5678);
    step("fault_pcw", 1, 32'h0000_0300, 0, 32'h0);

    // Timeout
    do_reset("rst2");
    step("to_req", 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < MW; i++) step("to_w", 0, 32'h0, 0, 32'h0);
    chk("to_not_yet", Fault, 1'b0);
    step("to_hit", 0, 32'h0, 0, 32'h0);
    chk("to_fault", Fault, 1'b1);
    chk("to_req_low", ImemReq, 1'b0);
    step("to_ack", 0, 32'h0, 1, 32'hCAFE_F00D);
    step("to_pcw", 1, 32'h0000_0040, 0, 32'h0);

    // Wrap of PC_plus4
    do_reset("rst3");
    step("wr_req", 0, 32'h0, 0, 32'h0);
    step("wr_ack", 0, 32'h0, 1, 32'h0000_0013);
    step("wr_ret", 1, 32'hFFFF_FFFC, 0, 32'h0);
    chk("wrap_pc4", PC_plus4, 32'h0000_0000);

    // Asynchronous reset in WAIT
    step("rw_w", 0, 32'h0, 0, 32'h0);
    chk("rw_in_wait", ImemReq, 1'b1);
    RST = 1;
    #1;
    model_reset();
    chk("rw_req_drop", ImemReq, 1'b0);
    chk("rw_pc", PC, RST_PC);
    chk("rw_instr", Instr, NOP);
    ImemAck = 1; ImemData = 32'hBAD0_0BAD;
    @(posedge CLK);
    #1;
    check_all("rw_hold");
    RST = 0; ImemAck = 0;
    step("rw_boot", 0, 32'h0, 0, 32'h0);
    chk("rw_req_after", ImemReq, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (m_fault) begin
        do_reset("rnd_rst");
      end else begin
        logic [31:0] npc;
        int sel;
        sel = $urandom_range(0, 11);
        npc = {$urandom()} & 32'hFFFF_FFFC;
        if (sel == 0) npc = npc | 32'(($urandom_range(1, 3)));
        if (sel == 1) npc = 32'hFFFF_FFFC;
        step("rnd", ($urandom_range(0, 2) == 0), npc,
             ($urandom_range(0, 3) == 0), $urandom());
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter: MAX_WAIT, 15, maximum wait cycles after the request cycle before fetch timeout (range 1..255).
REQ-003 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: PCWrite  input  1  control strobe; retire current instruction, load NextPC.
REQ-006 SHALL have port: NextPC  input  32  next PC from datapath (PC+4, branch or jump target).
REQ-007 SHALL have port: ImemReq  output  1  instruction memory request.
REQ-008 SHALL have port: ImemAddr  output  32  instruction memory word address.
REQ-009 SHALL have port: ImemAck  input  1  memory returns data this cycle.
REQ-010 SHALL have port: ImemData  input  32  instruction word, valid when ImemAck=1.
REQ-011 SHALL have port: Instr  output  32  instruction register (IR).
REQ-012 SHALL have port: opcode  output  7  Instr[6:0], feeds control FSM.
REQ-013 SHALL have port: funct3  output  3  Instr[14:12], feeds control FSM.
REQ-014 SHALL have port: PC  output  32  address of the instruction held in IR.
REQ-015 SHALL have port: PC_plus4  output  32  PC+4, modulo 2^32.
REQ-016 SHALL have port: InstrValid  output  1  IR holds a fetched instruction; control may advance.
REQ-017 SHALL have port: Fault  output  1  sticky fault (timeout or misaligned NextPC).

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, VALID, FAULT.
REQ-019 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-020 In REQ: ImemReq=1, ImemAddr=PC; ImemAck=1 -> latch ImemData into Instr, go VALID; else -> WAIT, wait counter cleared to 0.
REQ-021 In WAIT: ImemReq=1, ImemAddr=PC held stable; ImemAck=1 -> latch Instr, go VALID; else counter+1.
REQ-022 WAIT with no ack and counter==MAX_WAIT-1 at the edge SHALL go to FAULT, giving the timeout after exactly MAX_WAIT WAIT cycles.
REQ-023 In VALID: InstrValid=1, ImemReq=0; Instr and PC SHALL stay constant until PCWrite.
REQ-024 VALID with PCWrite=1 and NextPC[1:0]==2'b00 SHALL load PC<=NextPC and go REQ; InstrValid drops the next cycle.
REQ-025 VALID with PCWrite=1 and NextPC[1:0]!=2'b00 SHALL leave PC unchanged and go FAULT.
REQ-026 FAULT SHALL be absorbing until RST: Fault=1, ImemReq=0, InstrValid=0, PC and Instr frozen.
REQ-027 PCWrite outside VALID SHALL be ignored (no PC change, no state change).
REQ-028 ImemAck outside REQ/WAIT SHALL be ignored; Instr unchanged.
REQ-029 ImemAddr SHALL equal PC in every state; ImemReq SHALL be 1 only in REQ and WAIT.
REQ-030 opcode, funct3 and PC_plus4 SHALL be combinational from Instr/PC; 0xFFFFFFFC+4 = 0x00000000.
REQ-031 Best-case fetch latency: 1 cycle from entering REQ to InstrValid=1 (ack in REQ); PCWrite-to-InstrValid minimum 2 cycles.

Reset
REQ-032 RST=1 SHALL immediately (asynchronously) force state=IDLE, PC=RESET_PC, Instr=32'h0000_0013 (NOP), counter=0, ImemReq=0, InstrValid=0, Fault=0.
REQ-033 RST asserted during WAIT SHALL drop ImemReq in the same cycle; a later ImemAck SHALL not load Instr.
REQ-034 After RST release, the first ImemReq SHALL rise exactly 1 edge later (via IDLE->REQ).

Verification
REQ-035 Zero-wait fetch: reset, ImemAck=1 in REQ with ImemData=32'h00500093 -> Instr=0x00500093, opcode=7'b0010011, funct3=3'b000, PC=0, InstrValid=1.
REQ-036 Wait states: ack after 3 WAIT cycles -> ImemReq high 4 cycles, ImemAddr stable at PC, single Instr load, Fault=0.
REQ-037 Timeout: MAX_WAIT=15, no ack -> Fault=1 after 15 WAIT cycles, ImemReq=0, subsequent ack and PCWrite ignored.
REQ-038 Retire: VALID, PCWrite=1, NextPC=0x00000104 -> PC=0x104, PC_plus4=0x108, REQ next cycle with ImemAddr=0x104; misaligned NextPC=0x106 -> FAULT, PC unchanged.
REQ-039 Reset mid-WAIT: RST pulse while ImemReq=1 -> ImemReq=0 same cycle, PC=RESET_PC, Instr=0x00000013, then REQ one edge after release.
REQ-040 Spurious inputs: PCWrite in WAIT and ImemAck in VALID -> PC, Instr and state unchanged.
